// File: rtl/motion_detect_pkg.sv
// Shared types, default parameters and width helpers for the motion-detection stream.
package motion_detect_pkg;

    typedef enum logic [1:0] {
        MODE_HIGHLIGHT = 2'd0,
        MODE_MASK      = 2'd1,
        MODE_DIFF      = 2'd2,
        MODE_PASS      = 2'd3
    } mode_t;

    localparam int DEF_PIXEL_WIDTH  = 8;
    localparam int DEF_CHANNELS     = 3;
    localparam int DEF_FRAME_PIXELS = 442368;
    localparam int DEF_COUNT_WIDTH  = 20;

    // Channel sum never overflows: CHANNELS values of PIXEL_WIDTH bits each.
    function automatic int gray_sum_width(input int pixel_width, input int channels);
        return pixel_width + $clog2(channels);
    endfunction

endpackage

// File: rtl/motion_detect_stream_rgb_to_gray.sv
// Combinational grayscale: truncated mean of all channels of one pixel.
module rgb_to_gray
    import motion_detect_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int CHANNELS    = DEF_CHANNELS
) (
    input  logic [PIXEL_WIDTH*CHANNELS-1:0] pix,
    output logic [PIXEL_WIDTH-1:0]          gray
);

    localparam int SW = gray_sum_width(PIXEL_WIDTH, CHANNELS);

    logic [SW-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            sum = sum + SW'(pix[i*PIXEL_WIDTH +: PIXEL_WIDTH]);
        end
        gray = PIXEL_WIDTH'(sum / SW'(CHANNELS));
    end

endmodule

// File: rtl/motion_detect_stream.sv
// Three-stage FIFO-to-FIFO motion detector: grayscale both inputs, threshold the
// absolute difference, emit a mode-selected pixel and count motion pixels per frame.
module motion_detect_stream
    import motion_detect_pkg::*;
#(
    parameter int PIXEL_WIDTH  = DEF_PIXEL_WIDTH,
    parameter int CHANNELS     = DEF_CHANNELS,
    parameter int FRAME_PIXELS = DEF_FRAME_PIXELS,
    parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [PIXEL_WIDTH-1:0]          thresh,
    input  logic [1:0]                      mode,
    input  logic [PIXEL_WIDTH*CHANNELS-1:0] hl_color,
    input  logic [PIXEL_WIDTH*CHANNELS-1:0] bg_dout,
    input  logic                            bg_empty,
    output logic                            bg_rd_en,
    input  logic [PIXEL_WIDTH*CHANNELS-1:0] fr_dout,
    input  logic                            fr_empty,
    output logic                            fr_rd_en,
    output logic [PIXEL_WIDTH*CHANNELS-1:0] out_din,
    input  logic                            out_full,
    output logic                            out_wr_en,
    output logic [COUNT_WIDTH-1:0]          motion_count,
    output logic                            frame_done
);

    localparam int DW  = PIXEL_WIDTH * CHANNELS;
    localparam int PCW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
    localparam logic [PCW-1:0] LAST_IDX = PCW'(FRAME_PIXELS - 1);

    logic                   adv, pop, first_pix, last_pix;
    logic [PCW-1:0]         pix_cnt;
    logic [PIXEL_WIDTH-1:0] cfg_thresh, sel_thresh;
    mode_t                  cfg_mode, sel_mode;
    logic [DW-1:0]          cfg_color, sel_color;

    logic                   s1_valid, s1_last;
    logic [DW-1:0]          s1_bg, s1_fr, s1_color;
    logic [PIXEL_WIDTH-1:0] s1_thresh;
    mode_t                  s1_mode;

    logic                   s2_valid, s2_last;
    logic [PIXEL_WIDTH-1:0] s2_gray_bg, s2_gray_fr, s2_thresh;
    logic [DW-1:0]          s2_fr, s2_color;
    mode_t                  s2_mode;

    logic                   s3_valid, s3_last, s3_mask;
    logic [DW-1:0]          s3_data;

    logic [PIXEL_WIDTH-1:0] gray_bg, gray_fr, diff;
    logic                   mask;
    logic [DW-1:0]          pix_out;
    logic [COUNT_WIDTH-1:0] acc;

    assign adv        = !s3_valid || !out_full;
    assign pop        = reset && adv && !bg_empty && !fr_empty;
    assign bg_rd_en   = pop;
    assign fr_rd_en   = pop;
    assign out_wr_en  = reset && s3_valid && !out_full;
    assign out_din    = s3_data;
    assign frame_done = out_wr_en && s3_last;
    assign first_pix  = (pix_cnt == '0);
    assign last_pix   = (pix_cnt == LAST_IDX);

    // Config travels with each pixel so a new frame never recolours the tail of the old one.
    assign sel_thresh = first_pix ? thresh          : cfg_thresh;
    assign sel_mode   = first_pix ? mode_t'(mode)   : cfg_mode;
    assign sel_color  = first_pix ? hl_color        : cfg_color;

    always_ff @(posedge clock) begin
        if (!reset) begin
            pix_cnt    <= '0;
            cfg_thresh <= '0;
            cfg_mode   <= MODE_HIGHLIGHT;
            cfg_color  <= '0;
        end else if (pop) begin
            pix_cnt    <= last_pix ? '0 : pix_cnt + PCW'(1);
            cfg_thresh <= sel_thresh;
            cfg_mode   <= sel_mode;
            cfg_color  <= sel_color;
        end
    end

    rgb_to_gray #(.PIXEL_WIDTH(PIXEL_WIDTH), .CHANNELS(CHANNELS)) u_gray_bg (
        .pix  (s1_bg),
        .gray (gray_bg)
    );

    rgb_to_gray #(.PIXEL_WIDTH(PIXEL_WIDTH), .CHANNELS(CHANNELS)) u_gray_fr (
        .pix  (s1_fr),
        .gray (gray_fr)
    );

    always_comb begin
        diff    = (s2_gray_fr > s2_gray_bg) ? (s2_gray_fr - s2_gray_bg) : (s2_gray_bg - s2_gray_fr);
        mask    = (diff > s2_thresh);
        pix_out = s2_fr;
        case (s2_mode)
            MODE_HIGHLIGHT: pix_out = mask ? s2_color : s2_fr;
            MODE_MASK:      pix_out = {DW{mask}};
            MODE_DIFF:      pix_out = {CHANNELS{diff}};
            default:        pix_out = s2_fr;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
            s3_last  <= 1'b0;
            s3_mask  <= 1'b0;
            s3_data  <= '0;
        end else if (adv) begin
            s1_valid   <= pop;
            s1_bg      <= bg_dout;
            s1_fr      <= fr_dout;
            s1_last    <= last_pix;
            s1_thresh  <= sel_thresh;
            s1_mode    <= sel_mode;
            s1_color   <= sel_color;

            s2_valid   <= s1_valid;
            s2_gray_bg <= gray_bg;
            s2_gray_fr <= gray_fr;
            s2_fr      <= s1_fr;
            s2_last    <= s1_last;
            s2_thresh  <= s1_thresh;
            s2_mode    <= s1_mode;
            s2_color   <= s1_color;

            s3_valid   <= s2_valid;
            s3_data    <= pix_out;
            s3_mask    <= mask;
            s3_last    <= s2_last;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            acc          <= '0;
            motion_count <= '0;
        end else if (out_wr_en) begin
            if (s3_last) begin
                motion_count <= (acc == '1) ? acc : acc + COUNT_WIDTH'(s3_mask);
                acc          <= '0;
            end else if (s3_mask && (acc != '1)) begin
                acc <= acc + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: doc/motion_detect_stream.md
# motion_detect_stream

Parametrised single-block motion-detection datapath: pops paired background and frame pixels from two first-word-fall-through FIFOs, converts both to grayscale, thresholds the absolute difference, and writes a mode-selected output pixel to a downstream FIFO. It replaces the separate grayscale / subtract / highlight chain and its intermediate FIFOs between the input FIFOs and the output FIFO. It adds a generic channel count and pixel width, runtime threshold and highlight colour, output modes, and a per-frame motion-pixel count.

## Interface
- PIXEL_WIDTH, 8, bits per colour channel
- CHANNELS, 3, channels per pixel (1..4); bus width DW = PIXEL_WIDTH*CHANNELS
- FRAME_PIXELS, 442368, pixels per frame (768x576)
- COUNT_WIDTH, 20, width of motion count; must hold FRAME_PIXELS
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-low
- thresh  in  PIXEL_WIDTH  motion threshold, sampled at frame start
- mode  in  2  output mode, sampled at frame start
- hl_color  in  DW  highlight pixel value, sampled at frame start
- bg_dout  in  DW  background FIFO head
- bg_empty  in  1  background FIFO empty
- bg_rd_en  out  1  background FIFO pop
- fr_dout  in  DW  frame FIFO head
- fr_empty  in  1  frame FIFO empty
- fr_rd_en  out  1  frame FIFO pop
- out_din  out  DW  output pixel
- out_full  in  1  output FIFO full
- out_wr_en  out  1  output FIFO write
- motion_count  out  COUNT_WIDTH  mask-set pixels in last completed frame
- frame_done  out  1  one-cycle pulse when a frame's last pixel is written

## Operation
- Pipeline: S1 captures raw bg/fr pixels; S2 holds gray_bg, gray_fr, and the frame pixel; S3 holds out_din, mask, and last flag. Each stage has a valid bit.
- adv = !s3_valid | !out_full. All stages shift only when adv is high.
- Pop: bg_rd_en = fr_rd_en = adv & !bg_empty & !fr_empty. Both FIFOs are always popped together, never one alone.
- Grayscale: sum of channels (width PIXEL_WIDTH+clog2(CHANNELS)) divided by CHANNELS, truncated. For CHANNELS=1, gray equals the pixel.
- diff = |gray_fr - gray_bg|. mask = diff > thresh (strictly greater).
- Output by mode:
  - 0 HIGHLIGHT: mask ? hl_color : frame pixel.
  - 1 MASK: every channel all-ones if mask, else zero.
  - 2 DIFF: diff replicated to every channel.
  - 3 PASS: frame pixel unchanged.
- Frame tracking:
  - pix_cnt counts pops from 0 to FRAME_PIXELS-1, then wraps to 0.
  - On a pop with pix_cnt==0, latch thresh, mode, and hl_color for the whole frame. Mid-frame input changes are ignored.
  - A last flag is set on the pop with pix_cnt==FRAME_PIXELS-1 and travels with the pixel.
- Count:
  - acc increments on each output write with mask=1, saturating at all-ones.
  - On the write of the last-flagged pixel: motion_count <= acc + mask, frame_done=1, acc cleared.
  - If the next frame's first write falls in the same cycle, it counts into the cleared accumulator.
- Reset (reset==0 at a clock edge):
  - Clears all valid bits, pix_cnt, acc, motion_count, and latched config.
  - Latched config resets to mode 0, thresh 0, colour 0.
  - Outputs 0: bg_rd_en, fr_rd_en, out_wr_en, out_din, motion_count, frame_done.
  - Reset mid-frame discards in-flight pixels; the next pop is treated as pixel 0.

## Timing
- Pop in cycle N (combinational from empty/full). S1 valid N+1, S2 valid N+2, out_wr_en high in cycle N+3 with out_din. Latency is 3 cycles.
- out_wr_en = s3_valid & !out_full. No write occurs while full. S3 holds its data until written.
- Steady-state throughput: 1 pixel/cycle with no bubbles when both inputs are non-empty and the output is not full.
- While out_full is high with a full pipe: no pops, and all stage contents are held unchanged.
- Empty on either input inserts a bubble (valid=0). No partial pop occurs.
- frame_done is asserted in the same cycle as the last pixel's out_wr_en. motion_count updates on the following edge and holds until the next frame ends.

## Structure
- motion_detect_pkg holds:
  - the mode enum (MODE_HIGHLIGHT, MODE_MASK, MODE_DIFF, MODE_PASS);
  - default parameter constants;
  - the gray-sum width function.
- Sub-module rgb_to_gray: parametrised combinational channel sum/divide, instantiated twice in S1→S2.
- Integrates into the top between the existing 24-bit input FIFOs and the output FIFO. The frame-copy FIFO and the three 8-bit FIFOs are removed.

## Test plan
- Reset: hold reset=0 for 3 cycles with inputs non-empty → no pops, all outputs 0. Release → first out_wr_en exactly 3 cycles after the first pop.
- Threshold edge, mode 0, thresh=50, hl_color=0xFF0000:
  - bg=0x000000, fr=0x323232 (gray 50) → outputs fr unchanged;
  - fr=0x333333 (gray 51) → outputs 0xFF0000.
- Modes: same pixel pair bg=0x101010, fr=0x808080 under modes 1/2/3 → outputs 0xFFFFFF / 0x707070 / 0x808080.
- Backpressure: stream 16 pixels, assert out_full for 5 cycles mid-stream → pops stop, no writes, and the 16 outputs appear in order with none lost or duplicated.
- Frame count: FRAME_PIXELS=8, mask set on pixels 1,4,7 → frame_done pulses with the 8th write and motion_count=3. Changing mode after pixel 2 takes effect only from pixel 8.
- Mid-frame reset after 5 pops of an 8-pixel frame → next frame_done after 8 further pops, with the count covering only the post-reset pixels.
